csd2bin_seq: RTL

- Iterative, handshaked CSD-to-binary converter; the decode-side counterpart of the bin2csd encoder used around bkm_step.
- Accepts one W-digit CSD word (2 bits per digit) and accumulates it MSD-first, Horner style, one digit per enabled cycle.
- Returns a W-bit two's-complement result.
- Sits on bkm_step X/Y outputs where area matters more than throughput; replaces the combinational csd2bin there.

---
 rtl/csd2bin_seq_pkg.sv | 16 +
 rtl/csd2bin_seq_if.sv | 23 ++
 rtl/csd2bin_seq_dec.sv | 16 +
 rtl/csd2bin_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/csd2bin_seq_pkg.sv
// csd2bin_seq shared definitions: CSD digit codes and FSM states.
// Imported by the converter, its digit decoder and the bench.
package csd2bin_seq_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b11;
  localparam logic [1:0] CSD_ILL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csd2bin_seq_if.sv
// csd2bin_seq handshake bundle: CSD word in, binary result out.
// master drives words and takes results; slave is the converter.
interface csd2bin_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] x;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic           err;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, err
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, err
  );
endinterface

// File: rtl/csd2bin_seq_dec.sv
// csd_digit_dec: combinational CSD digit decoder.
// One-hot add/sub/illegal flags for serial CSD blocks.
module csd_digit_dec
  import csd2bin_seq_pkg::*;
(
  input  logic [1:0] code,
  output logic       add_one,
  output logic       sub_one,
  output logic       illegal
);

  assign add_one = (code == CSD_POS);
  assign sub_one = (code == CSD_NEG);
  assign illegal = (code == CSD_ILL);

endmodule

// File: rtl/csd2bin_seq.sv
// csd2bin_seq: serial MSD-first Horner CSD-to-binary converter.
// Define CSD2BIN_SEQ_CHECK_EN to build the malformed-CSD err check.
module csd2bin_seq
  import csd2bin_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         enable,
  csd2bin_seq_if.slave bus,
  output logic         busy
);

  state_t           state;
  state_t           state_nxt;
  logic [2*W-1:0]   sr;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_nxt;
  logic [W-1:0]     delta;
  logic [LOG2W-1:0] cnt;
  logic [1:0]       digit;
  logic             add;
  logic             sub;
  logic             ill;
  logic             accept;
  logic             take;

  // Most significant remaining digit sits at the top of the shift reg.
  assign digit = sr[2*W-1 -: 2];

  csd_digit_dec u_dec (
    .code    (digit),
    .add_one (add),
    .sub_one (sub),
    .illegal (ill)
  );

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;

  always_comb begin
    delta = '0;
    unique case (1'b1)
      ill:     delta = '0;
      add:     delta = W'(1);
      sub:     delta = '1;
      default: delta = '0;
    endcase
  end

  assign acc_nxt = (acc << 1) + delta;

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        IDLE: if (accept) state_nxt = CONV;
        CONV: if (cnt == '0) state_nxt = DONE;
        DONE: begin
          if (accept)    state_nxt = CONV;
          else if (take) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = enable &
                    ((state == IDLE) |
                     ((state == DONE) & bus.out_ready));
    bus.out_valid = enable & (state == DONE);
    busy          = (state == CONV);
  end

  assign bus.y = acc;

  always_ff @(posedge clk) begin
    if (srst) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (enable) begin
      if (accept) begin
        sr  <= bus.x;
        acc <= '0;
        cnt <= LOG2W'(W - 1);
      end else if (state == CONV) begin
        sr  <= sr << 2;
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef CSD2BIN_SEQ_CHECK_EN
  logic err_r;
  logic prev_nz;
  logic nz;

  assign nz = add | sub;

  // prev_nz holds the more significant neighbour of the current digit.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_r   <= 1'b0;
      prev_nz <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        err_r   <= 1'b0;
        prev_nz <= 1'b0;
      end else if (state == CONV) begin
        err_r   <= err_r | ill | (nz & prev_nz);
        prev_nz <= nz;
      end
    end
  end

  assign bus.err = err_r & (state == DONE);
`else
  assign bus.err = 1'b0;
`endif

endmodule
